// File: rtl/ss_adc_sequencer_if.sv
// rtl/ss_adc_sequencer_if.sv - conversion result port of the single-slope ADC sequencer
`timescale 1ns/1ps

interface ss_adc_sequencer_if #(
    parameter int CNT_W = 12,
    parameter int CH_W  = 2
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_data;
    logic [CH_W-1:0]  res_ch;
    logic             res_ovf;

    modport master (
        output res_valid,
        output res_data,
        output res_ch,
        output res_ovf,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_ch,
        input  res_ovf,
        output res_ready
    );
endinterface

// File: rtl/ss_adc_sequencer.sv
// rtl/ss_adc_sequencer.sv - single-slope ADC sequencer: channel scan, ramp control, trip counting
`timescale 1ns/1ps

module ss_adc_sequencer #(
    parameter int CNT_W            = 12,
    parameter int NUM_CH           = 4,
    parameter int CH_W             = 2,
    parameter int DISCHARGE_CYCLES = 64,
    parameter int SETTLE_CYCLES    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 comp_in,
    output logic                 ramp_en,
    output logic                 ramp_discharge,
    output logic [CH_W-1:0]      ch_sel,
    output logic                 busy,
    ss_adc_sequencer_if.master   res
);

    localparam int PH_MAX = (DISCHARGE_CYCLES > SETTLE_CYCLES) ? DISCHARGE_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  DIS_LAST = PH_W'(DISCHARGE_CYCLES - 1);
    localparam logic [PH_W-1:0]  SET_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        SETTLE,
        RAMP,
        HOLD
    } state_t;

    state_t            state;
    logic              comp_s1;
    logic              comp_s2;
    logic [NUM_CH-1:0] mask_q;
    logic [PH_W-1:0]   ph_cnt;
    logic [CNT_W-1:0]  conv_cnt;
    logic              restart;

    logic [CH_W-1:0]   first_ch;
    logic [CH_W-1:0]   next_ch;
    logic              has_next;

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_sel))) begin
                next_ch  = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            comp_s1        <= 1'b0;
            comp_s2        <= 1'b0;
            mask_q         <= '0;
            ph_cnt         <= '0;
            conv_cnt       <= '0;
            restart        <= 1'b0;
            ramp_en        <= 1'b0;
            ramp_discharge <= 1'b1;
            ch_sel         <= '0;
            busy           <= 1'b0;
            res.res_valid  <= 1'b0;
            res.res_data   <= '0;
            res.res_ch     <= '0;
            res.res_ovf    <= 1'b0;
        end else begin
            comp_s1 <= comp_in;
            comp_s2 <= comp_s1;

            case (state)
                IDLE: begin
                    ramp_discharge <= 1'b1;
                    ramp_en        <= 1'b0;
                    restart        <= 1'b0;
                    // start and a pending restart collapse into a single sweep
                    if ((start || restart) && (|ch_mask)) begin
                        mask_q   <= ch_mask;
                        ch_sel   <= first_ch;
                        conv_cnt <= '0;
                        ph_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= DISCHARGE;
                    end
                end

                DISCHARGE: begin
                    if (ph_cnt == DIS_LAST) begin
                        ph_cnt         <= '0;
                        ramp_discharge <= 1'b0;
                        state          <= SETTLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    if (ph_cnt == SET_LAST) begin
                        ph_cnt   <= '0;
                        conv_cnt <= '0;
                        ramp_en  <= 1'b1;
                        state    <= RAMP;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                RAMP: begin
                    // Synchronizer latency is deliberately left in the count.
                    if (comp_s2 || (conv_cnt == CNT_MAX)) begin
                        res.res_data   <= comp_s2 ? conv_cnt : CNT_MAX;
                        res.res_ovf    <= ~comp_s2;
                        res.res_ch     <= ch_sel;
                        res.res_valid  <= 1'b1;
                        ramp_en        <= 1'b0;
                        ramp_discharge <= 1'b1;
                        state          <= HOLD;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    ramp_discharge <= 1'b1;
                    ramp_en        <= 1'b0;
                    if (res.res_valid && res.res_ready) begin
                        res.res_valid <= 1'b0;
                        if (has_next) begin
                            ch_sel <= next_ch;
                            ph_cnt <= '0;
                            state  <= DISCHARGE;
                        end else begin
                            busy    <= 1'b0;
                            restart <= continuous;
                            state   <= IDLE;
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    ramp_en        <= 1'b0;
                    ramp_discharge <= 1'b1;
                    res.res_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ss_adc_sequencer.sv
// tb/tb_ss_adc_sequencer.sv - scoreboard bench for ss_adc_sequencer
`timescale 1ns/1ps

module tb_ss_adc_sequencer;

    typedef struct {
        logic [11:0] data;
        logic [1:0]  ch;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic       comp_in = 1'b0;
    logic       ramp_en;
    logic       ramp_discharge;
    logic [1:0] ch_sel;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ss_adc_sequencer_if #(.CNT_W(12), .CH_W(2)) res_if ();

    ss_adc_sequencer #(
        .CNT_W(12), .NUM_CH(4), .CH_W(2), .DISCHARGE_CYCLES(64), .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .continuous(continuous),
        .ch_mask(ch_mask),
        .comp_in(comp_in),
        .ramp_en(ramp_en),
        .ramp_discharge(ramp_discharge),
        .ch_sel(ch_sel),
        .busy(busy),
        .res(res_if)
    );

    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ramp(output bit to);
        int n = 0;
        while (!ramp_en && n < 20000) begin
            @(negedge clk);
            n++;
        end
        to = !ramp_en;
    endtask

    // Called on the first negedge with ramp_en high (ramp cycle 1); comp_in rises
    // on the negedge of ramp cycle "delay", so the captured count is delay + 1.
    task automatic drive_trip(input int delay, input logic [1:0] ch);
        repeat (delay - 1) @(negedge clk);
        comp_in = 1'b1;
        sb.push_back('{12'(delay + 1), ch, 1'b0});
    endtask

    task automatic wait_valid(output logic [11:0] d, output logic [1:0] c,
                              output logic o, output bit to);
        int n = 0;
        while (!res_if.res_valid && n < 6000) begin
            @(negedge clk);
            n++;
        end
        to = !res_if.res_valid;
        d  = res_if.res_data;
        c  = res_if.res_ch;
        o  = res_if.res_ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        res_if.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ramp_en !== 1'b0) begin errors++; $display("FAIL reset_ramp_en got %b expected 0", ramp_en); end
        checks++; if (ramp_discharge !== 1'b1) begin errors++; $display("FAIL reset_discharge got %b expected 1", ramp_discharge); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", res_if.res_valid); end
        checks++; if (res_if.res_data !== 12'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", res_if.res_data); end
        checks++; if (res_if.res_ch !== 2'd0 || ch_sel !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d/%0d expected 0/0", res_if.res_ch, ch_sel); end
        checks++; if (res_if.res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", res_if.res_ovf); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e; int n; bit to; logic [11:0] d; logic [1:0] c; logic o;
        ch_mask = 4'b0001;
        res_if.res_ready = 1'b0;
        pulse_start();
        checks++; if (busy !== 1'b1 || ch_sel !== 2'd0) begin errors++; $display("FAIL single_start got busy=%b ch_sel=%0d expected busy=1 ch_sel=0", busy, ch_sel); end
        n = 0;
        while (busy && ramp_discharge && n < 200) begin n++; @(negedge clk); end
        checks++; if (n !== 64) begin errors++; $display("FAIL single_discharge_len got %0d expected 64", n); end
        n = 0;
        while (busy && !ramp_discharge && !ramp_en && n < 50) begin n++; @(negedge clk); end
        checks++; if (n !== 4) begin errors++; $display("FAIL single_settle_len got %0d expected 4", n); end
        wait_ramp(to);
        checks++; if (to) begin errors++; $display("FAIL single_ramp_timeout got 0 expected 1"); end
        drive_trip(100, 2'd0);
        wait_valid(d, c, o, to);
        comp_in = 1'b0;
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL single_valid_timeout got 0 expected 1"); end
        checks++; if (d !== e.data) begin errors++; $display("FAIL single_data got %0d expected %0d", d, e.data); end
        checks++; if (c !== e.ch || o !== e.ovf) begin errors++; $display("FAIL single_ch_ovf got %0d/%b expected %0d/%b", c, o, e.ch, e.ovf); end
        res_if.res_ready = 1'b1;
        @(negedge clk);
        res_if.res_ready = 1'b0;
        checks++; if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin errors++; $display("FAIL single_done got busy=%b valid=%b expected 0/0", busy, res_if.res_valid); end
    endtask

    task automatic test_two_channels();
        exp_t e; bit to; logic [11:0] d; logic [1:0] c; logic o;
        int delays[2] = '{20, 40};
        logic [1:0] chs[2] = '{2'd1, 2'd3};
        ch_mask = 4'b1010;
        res_if.res_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_ramp(to);
            checks++; if (to || ch_sel !== chs[k]) begin errors++; $display("FAIL two_ch_sel got %0d expected %0d", ch_sel, chs[k]); end
            drive_trip(delays[k], chs[k]);
            wait_valid(d, c, o, to);
            comp_in = 1'b0;
            e = sb.pop_front();
            checks++; if (to || d !== e.data || c !== e.ch || o !== e.ovf) begin
                errors++; $display("FAIL two_result got %0d ch %0d ovf %b expected %0d ch %0d ovf %b", d, c, o, e.data, e.ch, e.ovf);
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL two_idle got busy=%b expected 0", busy); end
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_overflow();
        exp_t e; bit to; logic [11:0] d; logic [1:0] c; logic o;
        ch_mask = 4'b0001;
        res_if.res_ready = 1'b0;
        comp_in = 1'b0;
        pulse_start();
        wait_ramp(to);
        sb.push_back('{12'hFFF, 2'd0, 1'b1});
        wait_valid(d, c, o, to);
        e = sb.pop_front();
        checks++; if (to || d !== e.data || o !== e.ovf || c !== e.ch) begin
            errors++; $display("FAIL ovf_result got %0d ovf %b ch %0d expected %0d ovf %b ch %0d", d, o, c, e.data, e.ovf, e.ch);
        end
        checks++; if (ramp_discharge !== 1'b1 || ramp_en !== 1'b0) begin errors++; $display("FAIL ovf_hold_ramp got dis=%b en=%b expected 1/0", ramp_discharge, ramp_en); end
        res_if.res_ready = 1'b1;
        @(negedge clk);
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e; bit to; bit bad; logic [11:0] d; logic [1:0] c; logic o;
        ch_mask = 4'b0011;
        res_if.res_ready = 1'b0;
        pulse_start();
        wait_ramp(to);
        drive_trip(10, 2'd0);
        wait_valid(d, c, o, to);
        comp_in = 1'b0;
        e = sb.pop_front();
        checks++; if (to || d !== e.data || c !== e.ch) begin errors++; $display("FAIL bp_first got %0d ch %0d expected %0d ch %0d", d, c, e.data, e.ch); end
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!res_if.res_valid || res_if.res_data !== e.data || res_if.res_ch !== e.ch || ch_sel !== 2'd0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_stable got data %0d ch_sel %0d expected %0d ch_sel 0", res_if.res_data, ch_sel, e.data); end
        res_if.res_ready = 1'b1;
        @(negedge clk);
        res_if.res_ready = 1'b0;
        checks++; if (res_if.res_valid !== 1'b0 || ch_sel !== 2'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_advance got valid=%b ch_sel=%0d busy=%b expected 0/1/1", res_if.res_valid, ch_sel, busy);
        end
        wait_ramp(to);
        drive_trip(5, 2'd1);
        wait_valid(d, c, o, to);
        comp_in = 1'b0;
        e = sb.pop_front();
        checks++; if (to || d !== e.data || c !== e.ch) begin errors++; $display("FAIL bp_second got %0d ch %0d expected %0d ch %0d", d, c, e.data, e.ch); end
        res_if.res_ready = 1'b1;
        @(negedge clk);
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_continuous();
        exp_t e; bit to; int gap; int hi; logic [11:0] d; logic [1:0] c; logic o;
        ch_mask = 4'b0001;
        continuous = 1'b1;
        res_if.res_ready = 1'b1;
        pulse_start();
        ch_mask = 4'b0100;
        wait_ramp(to);
        drive_trip(30, 2'd0);
        wait_valid(d, c, o, to);
        comp_in = 1'b0;
        e = sb.pop_front();
        checks++; if (to || d !== e.data || c !== e.ch) begin errors++; $display("FAIL cont_first got %0d ch %0d expected %0d ch %0d", d, c, e.data, e.ch); end
        @(negedge clk);
        gap = 0;
        while (!busy && gap < 10) begin gap++; @(negedge clk); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL cont_gap got %0d expected 1", gap); end
        wait_ramp(to);
        continuous = 1'b0;
        drive_trip(7, 2'd2);
        wait_valid(d, c, o, to);
        comp_in = 1'b0;
        e = sb.pop_front();
        checks++; if (to || d !== e.data || c !== e.ch) begin errors++; $display("FAIL cont_last got %0d ch %0d expected %0d ch %0d", d, c, e.data, e.ch); end
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) hi++;
            @(negedge clk);
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL cont_stop got busy cycles %0d expected 0", hi); end
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit to; int hi;
        ch_mask = 4'b0001;
        pulse_start();
        wait_ramp(to);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ramp_en !== 1'b0 || ramp_discharge !== 1'b1 || res_if.res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got en=%b dis=%b valid=%b busy=%b expected 0/1/0/0", ramp_en, ramp_discharge, res_if.res_valid, busy);
        end
        rst_n = 1'b1;
        ch_mask = 4'b0000;
        pulse_start();
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || ramp_discharge !== 1'b1 || res_if.res_valid) hi++;
            @(negedge clk);
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL zero_mask got active cycles %0d expected 0", hi); end
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        test_reset();
        test_single();
        test_two_channels();
        test_overflow();
        test_backpressure();
        test_continuous();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
